// File: rtl/pc_seq_pkg.sv
// Shared types and opcode constants for the PC sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMem,
        StHalted
    } seq_state_t;

    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_BRZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Opcodes 000..011 are ALU operations.
    function automatic logic is_alu(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bundle between the sequencer (master) and PC / ROM / data-memory side (slave).
interface pc_sequencer_if;
    logic        Start;
    logic [8:0]  Instr;
    logic [7:0]  PgmCtr;
    logic        ZeroFlag;
    logic        MemAck;
    logic        Inc;
    logic        BranchEn;
    logic [3:0]  Target;
    logic        MemReq;
    logic        MemWe;
    logic        RegWe;
    logic        Busy;
    logic        Done;
    logic        Fault;
    logic [15:0] RetireCnt;

    modport master (
        input  Start, Instr, PgmCtr, ZeroFlag, MemAck,
        output Inc, BranchEn, Target, MemReq, MemWe, RegWe, Busy, Done, Fault, RetireCnt
    );

    modport slave (
        output Start, Instr, PgmCtr, ZeroFlag, MemAck,
        input  Inc, BranchEn, Target, MemReq, MemWe, RegWe, Busy, Done, Fault, RetireCnt
    );
endinterface

// File: rtl/seq_watchdog.sv
// Counts consecutive MEM-wait cycles; expired flags the cycle whose increment reaches MEM_TIMEOUT.
module seq_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MEM_TIMEOUT);
    localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != MaxCnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Combinational so the fault lands on the same edge the counter reaches the limit.
    assign expired = en && (r_cnt == LastCnt);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-sequencing FSM: decodes opcodes, drives PC/regfile/memory strobes, counts retirements.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [7:0]  LAST_PC     = 8'hFF,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_sequencer_if.master bus
);
    seq_state_t  r_state, w_state_nxt;
    logic        r_fault;
    logic        r_mem_st;
    logic [15:0] r_retire;

    logic [2:0]  w_op;
    logic        w_inc, w_br, w_memreq, w_memwe, w_regwe;
    logic [3:0]  w_target;
    logic        w_retire, w_wd_clear, w_wd_en, w_wd_expired, w_fault_set;

    assign w_op = bus.Instr[8:6];

    seq_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (w_wd_clear),
        .en     (w_wd_en),
        .expired(w_wd_expired)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= StIdle;
            r_fault  <= 1'b0;
            r_mem_st <= 1'b0;
            r_retire <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fault_set) r_fault <= 1'b1;
            if (r_state == StExec) r_mem_st <= (w_op == OP_ST);
            if (w_retire && (r_retire != 16'hFFFF)) r_retire <= r_retire + 16'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_br        = 1'b0;
        w_target    = 4'h0;
        w_memreq    = 1'b0;
        w_memwe     = 1'b0;
        w_regwe     = 1'b0;
        w_retire    = 1'b0;
        w_wd_clear  = 1'b0;
        w_wd_en     = 1'b0;
        w_fault_set = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.Start) w_state_nxt = StFetch;
            end
            StFetch: w_state_nxt = StExec;
            StExec: begin
                w_target = bus.Instr[3:0];
                if (is_alu(w_op)) begin
                    w_regwe     = 1'b1;
                    w_inc       = 1'b1;
                    w_retire    = 1'b1;
                    w_state_nxt = StFetch;
                end else begin
                    unique case (w_op)
                        OP_BRZ: begin
                            w_br        = bus.ZeroFlag;
                            w_inc       = !bus.ZeroFlag;
                            w_retire    = 1'b1;
                            w_state_nxt = StFetch;
                        end
                        OP_LD, OP_ST: begin
                            w_memreq    = 1'b1;
                            w_memwe     = (w_op == OP_ST);
                            w_wd_clear  = 1'b1;
                            w_state_nxt = StMem;
                        end
                        default: begin
                            w_retire    = 1'b1;
                            w_state_nxt = StHalted;
                        end
                    endcase
                end
            end
            StMem: begin
                w_memreq = 1'b1;
                w_memwe  = r_mem_st;
                if (bus.MemAck) begin
                    w_inc       = 1'b1;
                    w_regwe     = !r_mem_st;
                    w_retire    = 1'b1;
                    w_state_nxt = StFetch;
                end else begin
                    w_wd_en = 1'b1;
                    if (w_wd_expired) begin
                        w_fault_set = 1'b1;
                        w_state_nxt = StHalted;
                    end
                end
            end
            StHalted: w_state_nxt = StHalted;
            default:  w_state_nxt = StIdle;
        endcase

        // Retiring the last instruction ends the program unless it branched away.
        if (w_retire && (bus.PgmCtr == LAST_PC) && !w_br) w_state_nxt = StHalted;
    end

    assign bus.Inc       = w_inc;
    assign bus.BranchEn  = w_br;
    assign bus.Target    = w_target;
    assign bus.MemReq    = w_memreq;
    assign bus.MemWe     = w_memwe;
    assign bus.RegWe     = w_regwe;
    assign bus.Busy      = (r_state == StFetch) || (r_state == StExec) || (r_state == StMem);
    assign bus.Done      = (r_state == StHalted);
    assign bus.Fault     = r_fault;
    assign bus.RetireCnt = r_retire;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with LAST_PC=8'h05 and MEM_TIMEOUT=15.
module tb_pc_sequencer;
    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;

    localparam logic [8:0] I_ALU  = 9'b000_000000;
    localparam logic [8:0] I_BRZ  = 9'b110_00_1110;
    localparam logic [8:0] I_BRZ0 = 9'b110_00_0000;
    localparam logic [8:0] I_LD   = 9'b100_000000;
    localparam logic [8:0] I_ST   = 9'b101_000000;
    localparam logic [8:0] I_HALT = 9'b111_000000;

    // {Inc, BranchEn, Target, MemReq, MemWe, RegWe}
    localparam logic [8:0] C_NONE  = 9'b0_0_0000_0_0_0;
    localparam logic [8:0] C_ALU   = 9'b1_0_0000_0_0_1;
    localparam logic [8:0] C_BRT   = 9'b0_1_1110_0_0_0;
    localparam logic [8:0] C_BRN   = 9'b1_0_1110_0_0_0;
    localparam logic [8:0] C_LDREQ = 9'b0_0_0000_1_0_0;
    localparam logic [8:0] C_LDACK = 9'b1_0_0000_1_0_1;
    localparam logic [8:0] C_STREQ = 9'b0_0_0000_1_1_0;
    localparam logic [8:0] C_STACK = 9'b1_0_0000_1_1_0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .LAST_PC    (8'h05),
        .MEM_TIMEOUT(15)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ctl();
        return {bus.Inc, bus.BranchEn, bus.Target, bus.MemReq, bus.MemWe, bus.RegWe};
    endfunction

    // {Busy, Done, Fault}
    function automatic logic [2:0] sts();
        return {bus.Busy, bus.Done, bus.Fault};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        settle();
    endtask

    // Leaves the core in FETCH with the given instruction presented.
    task automatic start_run(input logic [8:0] instr);
        bus.Instr = instr;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        settle();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        Reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.Instr    = I_ALU;
        bus.PgmCtr   = 8'h10;
        bus.ZeroFlag = 1'b0;
        bus.MemAck   = 1'b1;
        do_reset();
        check("reset_ctl", ctl(), C_NONE);
        check("reset_sts", sts(), 3'b000);
        check("reset_cnt", bus.RetireCnt, 0);
        bus.MemAck = 1'b0;

        // ALU run: one retirement every two cycles
        start_run(I_ALU);
        for (int i = 0; i < 3; i++) begin
            check("alu_fetch_ctl", ctl(), C_NONE);
            check("alu_fetch_busy", bus.Busy, 1);
            step();
            check("alu_exec_ctl", ctl(), C_ALU);
            step();
        end
        check("alu_cnt3", bus.RetireCnt, 3);

        // BRZ taken then not taken
        bus.Instr    = I_BRZ;
        bus.ZeroFlag = 1'b1;
        step();
        check("brz_taken", ctl(), C_BRT);
        step();
        bus.ZeroFlag = 1'b0;
        settle();
        check("brz_fetch", ctl(), C_NONE);
        step();
        check("brz_not_taken", ctl(), C_BRN);
        step();
        check("brz_cnt5", bus.RetireCnt, 5);

        // Ack outside MEM is ignored
        bus.Instr  = I_LD;
        bus.MemAck = 1'b1;
        settle();
        check("ack_in_fetch", ctl(), C_NONE);
        bus.MemAck = 1'b0;

        // LD, ack on third MEM cycle
        step();
        check("ld_exec", ctl(), C_LDREQ);
        step();
        check("ld_mem1", ctl(), C_LDREQ);
        step();
        check("ld_mem2", ctl(), C_LDREQ);
        step();
        bus.MemAck = 1'b1;
        settle();
        check("ld_ack", ctl(), C_LDACK);
        step();
        bus.MemAck = 1'b0;
        bus.Instr  = I_ST;
        settle();
        check("ld_cnt6", bus.RetireCnt, 6);
        check("ld_back_fetch", sts(), 3'b100);

        // ST, same delay
        step();
        check("st_exec", ctl(), C_STREQ);
        step();
        check("st_mem1", ctl(), C_STREQ);
        step();
        check("st_mem2", ctl(), C_STREQ);
        step();
        bus.MemAck = 1'b1;
        settle();
        check("st_ack", ctl(), C_STACK);
        step();
        bus.MemAck = 1'b0;
        settle();
        check("st_cnt7", bus.RetireCnt, 7);

        // Reset mid-MEM with RetireCnt=2
        do_reset();
        start_run(I_ALU);
        step();
        step();
        step();
        step();
        check("rm_cnt2", bus.RetireCnt, 2);
        bus.Instr = I_LD;
        step();
        step();
        check("rm_in_mem", ctl(), C_LDREQ);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        settle();
        check("rm_ctl", ctl(), C_NONE);
        check("rm_sts", sts(), 3'b000);
        check("rm_cnt0", bus.RetireCnt, 0);
        start_run(I_ALU);
        check("rm_resume_busy", bus.Busy, 1);
        step();
        check("rm_resume_exec", ctl(), C_ALU);
        step();
        check("rm_resume_cnt", bus.RetireCnt, 1);

        // Timeout on ST with no ack
        bus.Instr = I_ST;
        step();
        check("to_exec", ctl(), C_STREQ);
        step();
        for (int i = 0; i < 15; i++) begin
            check("to_no_inc", bus.Inc, 0);
            check("to_no_fault", bus.Fault, 0);
            check("to_memreq", bus.MemReq, 1);
            step();
        end
        check("to_sts", sts(), 3'b011);
        check("to_cnt", bus.RetireCnt, 1);
        check("to_ctl", ctl(), C_NONE);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        check("to_start_ignored", sts(), 3'b011);

        // HALT opcode
        do_reset();
        start_run(I_HALT);
        step();
        check("halt_exec", ctl(), C_NONE);
        step();
        check("halt_sts", sts(), 3'b010);
        check("halt_cnt", bus.RetireCnt, 1);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        check("halt_start_ignored", sts(), 3'b010);

        // PgmCtr == LAST_PC retiring an ALU op
        do_reset();
        bus.PgmCtr = 8'h05;
        start_run(I_ALU);
        step();
        check("last_exec", ctl(), C_ALU);
        step();
        check("last_halted", sts(), 3'b010);
        check("last_cnt", bus.RetireCnt, 1);

        // Taken zero-offset branch at LAST_PC does not halt
        do_reset();
        bus.ZeroFlag = 1'b1;
        start_run(I_BRZ0);
        step();
        check("self_loop_br", ctl(), 9'b0_1_0000_0_0_0);
        step();
        check("self_loop_fetch", sts(), 3'b100);

        // PC at 8'hFF with LAST_PC=5: plain increment, no flag
        do_reset();
        bus.ZeroFlag = 1'b0;
        bus.PgmCtr   = 8'hFF;
        start_run(I_ALU);
        step();
        check("wrap_exec", ctl(), C_ALU);
        step();
        check("wrap_sts", sts(), 3'b100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
